// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory ready in, all datapath enables out.
// master = sequencing FSM, slave = datapath/memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       op_code;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             PCWriteCondNe;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op_code, mem_ready,
    output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, state, illegal_op, instr_count
  );

  modport slave (
    output op_code, mem_ready,
    input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, state, illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM: one state per cycle, enables registered from the next state.
// FETCH/MEM_READ/MEM_WRITE hold on !mem_ready; FETCH IRWrite/PCWrite follow mem_ready directly.
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       pc_write;
    logic       pc_cond;
    logic       pc_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t           state_q;
  state_t           state_nx;
  logic [5:0]       op_q;
  logic [5:0]       op_nx;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl_q;
  logic             rdy;
  logic             retire;
  logic             op_legal;

  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ)  ||
           (op == OP_BNE)   || (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_LW)    || (op == OP_SW);
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_op     = 2'b01;
        c.pc_source  = 2'b01;
        c.pc_cond    = (op == OP_BEQ);
        c.pc_cond_ne = (op == OP_BNE);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = (op == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_I_WB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign op_legal = is_legal(bus.op_code);
  assign op_nx    = (state_q == S_DECODE) ? bus.op_code : op_q;

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  state_nx = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op_code)
          OP_RTYPE:        state_nx = S_R_EXEC;
          OP_LW, OP_SW:    state_nx = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  state_nx = S_BRANCH;
          OP_J:            state_nx = S_JUMP;
          OP_ADDI, OP_ANDI: state_nx = S_I_EXEC;
          default:         state_nx = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_nx = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_nx = rdy ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_nx = S_FETCH;
      S_MEM_WRITE: state_nx = rdy ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_nx = S_R_WB;
      S_R_WB:      state_nx = S_FETCH;
      S_BRANCH:    state_nx = S_FETCH;
      S_JUMP:      state_nx = S_FETCH;
      S_I_EXEC:    state_nx = S_I_WB;
      S_I_WB:      state_nx = S_FETCH;
      default:     state_nx = S_IDLE;
    endcase
  end

  // DECODE->FETCH on an illegal opcode is excluded because DECODE is not terminal.
  assign retire = (state_nx == S_FETCH) &&
                  (state_q inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_I_WB});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_nx;
      op_q    <= op_nx;
      ctrl_q  <= decode(state_nx, op_nx);
      if (retire) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.PCWrite       = ctrl_q.pc_write | (ctrl_q.fetch & rdy);
  assign bus.PCWriteCond   = ctrl_q.pc_cond;
  assign bus.PCWriteCondNe = ctrl_q.pc_cond_ne;
  assign bus.IorD          = ctrl_q.iord;
  assign bus.MemRead       = ctrl_q.mem_read;
  assign bus.MemWrite      = ctrl_q.mem_write;
  assign bus.IRWrite       = ctrl_q.fetch & rdy;
  assign bus.MemtoReg      = ctrl_q.mem_to_reg;
  assign bus.RegDst        = ctrl_q.reg_dst;
  assign bus.RegWrite      = ctrl_q.reg_write;
  assign bus.ALUSrcA       = ctrl_q.alu_src_a;
  assign bus.ALUSrcB       = ctrl_q.alu_src_b;
  assign bus.ALUOp         = ctrl_q.alu_op;
  assign bus.PCSource      = ctrl_q.pc_source;
  assign bus.state         = state_q;
  assign bus.illegal_op    = (state_q == S_DECODE) && !op_legal;
  assign bus.instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table of per-cycle vectors plus an addi loop that wraps the 4-bit retire counter.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if #(.CNT_W(4)) bus ();

  multicycle_control #(.MEM_WAIT_EN(1'b1), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [17:0] ctl;
    logic [3:0] cnt;
  } row_t;

  row_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] act;

  assign act = {bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNe, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                bus.illegal_op};

  function automatic logic [17:0] mk(input logic pcw, input logic pcc, input logic pcn,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic irw, input logic m2r, input logic rdst,
                                     input logic rw, input logic srca, input logic [1:0] srcb,
                                     input logic [1:0] aluop, input logic [1:0] pcsrc,
                                     input logic ill);
    return {pcw, pcc, pcn, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [17:0] ctl, input logic [3:0] cnt);
    row_t r;
    r.rst = rst; r.op = op; r.rdy = rdy; r.st = st; r.ctl = ctl; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input int idx, input logic [17:0] a, input logic [17:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, a, e);
    end
  endtask

  // Invariants checked every cycle once out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (bus.MemRead && bus.MemWrite) begin
        n_bad++;
        $display("FAIL mem_excl: MemRead and MemWrite both 1 in state %0d", bus.state);
      end
      n_cmp++;
      if (bus.RegWrite && !(bus.state inside {4'd5, 4'd8, 4'd12})) begin
        n_bad++;
        $display("FAIL regwrite_state: RegWrite 1 in state %0d, allowed only 5/8/12", bus.state);
      end
    end
  end

  localparam logic [5:0] X = 6'h3f;

  initial begin
    logic [17:0] c_idle, c_fr, c_fw, c_dec, c_ill, c_ma, c_mr, c_mwb, c_mw;
    logic [17:0] c_rex, c_rwb, c_beq, c_bne, c_j, c_iadd, c_iand, c_iwb;
    logic [3:0] exp_cnt;

    c_idle = '0;
    c_fr   = mk(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    c_fw   = mk(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    c_dec  = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    c_ill  = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    c_ma   = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    c_mr   = mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_mwb  = mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    c_mw   = mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_rex  = mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    c_rwb  = mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    c_beq  = mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    c_bne  = mk(0,0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    c_j    = mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
    c_iadd = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    c_iand = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0);
    c_iwb  = mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);

    // rst, op, rdy, state, ctl, count -- one row per cycle
    add(1, X, 1, 0, c_idle, 0);
    add(0, X, 1, 0, c_idle, 0);
    add(0, X, 1, 1, c_fr, 0);            // lw, no waits
    add(0, 6'b100011, 1, 2, c_dec, 0);
    add(0, 6'b000000, 1, 3, c_ma, 0);
    add(0, X, 1, 4, c_mr, 0);
    add(0, X, 1, 5, c_mwb, 0);
    add(0, X, 1, 1, c_fr, 1);
    add(0, 6'b000000, 1, 2, c_dec, 1);   // R-type aborted by reset
    add(0, X, 1, 7, c_rex, 1);
    add(1, X, 1, 0, c_idle, 0);
    add(0, X, 1, 0, c_idle, 0);
    add(0, X, 0, 1, c_fw, 0);            // fetch stalled two cycles
    add(0, X, 0, 1, c_fw, 0);
    add(0, X, 1, 1, c_fr, 0);
    add(0, 6'b101011, 1, 2, c_dec, 0);   // sw, three wait cycles
    add(0, X, 1, 3, c_ma, 0);
    add(0, X, 0, 6, c_mw, 0);
    add(0, X, 0, 6, c_mw, 0);
    add(0, X, 0, 6, c_mw, 0);
    add(0, X, 1, 6, c_mw, 0);
    add(0, X, 1, 1, c_fr, 1);
    add(0, 6'b000100, 1, 2, c_dec, 1);   // beq
    add(0, X, 1, 9, c_beq, 1);
    add(0, X, 1, 1, c_fr, 2);
    add(0, 6'b000101, 1, 2, c_dec, 2);   // bne
    add(0, X, 1, 9, c_bne, 2);
    add(0, X, 1, 1, c_fr, 3);
    add(0, 6'b111111, 1, 2, c_ill, 3);   // illegal
    add(0, X, 1, 1, c_fr, 3);
    add(0, 6'b001100, 1, 2, c_dec, 3);   // andi
    add(0, X, 1, 11, c_iand, 3);
    add(0, X, 1, 12, c_iwb, 3);
    add(0, X, 1, 1, c_fr, 4);
    add(0, 6'b000010, 1, 2, c_dec, 4);   // j
    add(0, X, 1, 10, c_j, 4);
    add(0, X, 1, 1, c_fr, 5);
    add(0, 6'b000000, 1, 2, c_dec, 5);   // R-type complete
    add(0, X, 1, 7, c_rex, 5);
    add(0, X, 1, 8, c_rwb, 5);
    add(0, X, 1, 1, c_fr, 6);
    add(0, 6'b100011, 1, 2, c_dec, 6);   // lw, one read wait
    add(0, X, 1, 3, c_ma, 6);
    add(0, X, 0, 4, c_mr, 6);
    add(0, X, 1, 4, c_mr, 6);
    add(0, X, 1, 5, c_mwb, 6);
    add(0, X, 1, 1, c_fr, 7);

    reset = 1'b1;
    bus.op_code = X;
    bus.mem_ready = 1'b1;

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      bus.op_code = tbl[i].op;
      bus.mem_ready = tbl[i].rdy;
      @(negedge clk);
      chk("state", i, {14'd0, bus.state}, {14'd0, tbl[i].st});
      chk("ctrl", i, act, tbl[i].ctl);
      chk("count", i, {14'd0, bus.instr_count}, {14'd0, tbl[i].cnt});
      @(posedge clk);
      #1;
    end

    // Now in DECODE with 7 retired; 16 addi take the 4-bit counter all the way round.
    exp_cnt = 4'd7;
    for (int k = 1; k <= 16; k++) begin
      bus.op_code = 6'b001000;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("addi_dec", k, {14'd0, bus.state}, 18'd2);
      @(posedge clk); #1;
      bus.op_code = X;
      @(negedge clk);
      chk("addi_exec", k, act, c_iadd);
      @(posedge clk); #1;
      @(negedge clk);
      chk("addi_wb", k, {14'd0, bus.state}, 18'd12);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
      chk("addi_cnt", k, {14'd0, bus.instr_count}, {14'd0, exp_cnt});
      if (k == 9) chk("wrap_zero", k, {14'd0, bus.instr_count}, 18'd0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
